// File: rtl/dir_answer_packer_if.sv
// Handshake bundle between the direction detector, the answer packer and the manager.
// The slave modport is the packer's view; master is the surrounding logic's view.
interface dir_answer_packer_if #(
  parameter int unsigned SIZE_W = 12
);
  logic [2:0]        i_dir;
  logic              i_dir_valid;
  logic              i_dir_last;
  logic              o_dir_ready;
  logic              i_tmanager_ready;
  logic              o_tanswer_ready;
  logic [7:0]        o_tanswer_data;
  logic              o_tanswer_data_last;
  logic [SIZE_W-1:0] o_packet_size_in_bytes;
  logic [7:0]        o_packet_count;

  modport slave (
    input  i_dir, i_dir_valid, i_dir_last, i_tmanager_ready,
    output o_dir_ready, o_tanswer_ready, o_tanswer_data, o_tanswer_data_last,
    output o_packet_size_in_bytes, o_packet_count
  );

  modport master (
    output i_dir, i_dir_valid, i_dir_last, i_tmanager_ready,
    input  o_dir_ready, o_tanswer_ready, o_tanswer_data, o_tanswer_data_last,
    input  o_packet_size_in_bytes, o_packet_count
  );
endinterface

// File: rtl/dir_answer_packer.sv
// Buffers direction codes into a FIFO, then replays them as one answer packet
// to the manager; collection and sending alternate under a two-state FSM.
module dir_answer_packer #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned SIZE_W = 12
) (
  input logic               i_clk,
  input logic               i_rst,
  dir_answer_packer_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  localparam logic ST_COLLECT = 1'b0;
  localparam logic ST_SEND    = 1'b1;

  logic              state_q, state_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              dir_ready_q, dir_ready_d;
  logic              ans_valid_q, ans_valid_d;
  logic [2:0]        ans_data_q, ans_data_d;
  logic              ans_last_q, ans_last_d;
  logic [SIZE_W-1:0] size_q, size_d;
  logic [7:0]        pkt_q, pkt_d;
  logic [2:0]        mem [DEPTH];

  logic accept, pop;

  assign accept = bus.i_dir_valid & dir_ready_q;
  assign pop    = ans_valid_q & bus.i_tmanager_ready;

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    size_d      = size_q;
    pkt_d       = pkt_q;
    ans_valid_d = ans_valid_q;
    ans_data_d  = ans_data_q;
    ans_last_d  = ans_last_q;

    // accept only happens in COLLECT and pop only in SEND, so they never overlap
    count_d = count_q + CW'(accept) - CW'(pop);
    if (accept) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)    rd_ptr_d = rd_ptr_q + AW'(1);

    case (state_q)
      ST_COLLECT: begin
        if (accept && (bus.i_dir_last || count_d == CW'(DEPTH))) begin
          state_d = ST_SEND;
          size_d  = SIZE_W'(count_d);
        end
      end
      ST_SEND: begin
        // Output stage reloads only when empty or consumed, so it holds while stalled
        if (!ans_valid_q || pop) begin
          ans_valid_d = (count_d != '0);
          ans_last_d  = (count_d == CW'(1));
          if (count_d != '0) ans_data_d = mem[rd_ptr_d];
          if (pop && count_d == '0) begin
            state_d = ST_COLLECT;
            pkt_d   = pkt_q + 8'd1;
          end
        end
      end
      default: state_d = ST_COLLECT;
    endcase

    dir_ready_d = (state_d == ST_COLLECT) && (count_d < CW'(DEPTH));
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q     <= ST_COLLECT;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      dir_ready_q <= 1'b0;
      ans_valid_q <= 1'b0;
      ans_data_q  <= '0;
      ans_last_q  <= 1'b0;
      size_q      <= '0;
      pkt_q       <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      dir_ready_q <= dir_ready_d;
      ans_valid_q <= ans_valid_d;
      ans_data_q  <= ans_data_d;
      ans_last_q  <= ans_last_d;
      size_q      <= size_d;
      pkt_q       <= pkt_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (accept) mem[wr_ptr_q] <= bus.i_dir;
  end

  assign bus.o_dir_ready            = dir_ready_q;
  assign bus.o_tanswer_ready        = ans_valid_q;
  assign bus.o_tanswer_data         = {5'b00000, ans_data_q};
  assign bus.o_tanswer_data_last    = ans_last_q;
  assign bus.o_packet_size_in_bytes = size_q;
  assign bus.o_packet_count         = pkt_q;
endmodule
